// File: rtl/group_update_sequencer.sv
// Colour-group p-bit update sequencer: enables one group's mask for a dwell period, then a guard cycle.
// Optional build macro GROUP_SKIP_EMPTY_EN: groups whose mask is all-zero are skipped entirely.
module group_update_sequencer #(
    parameter int N_PBITS  = 459,
    parameter int N_GROUPS = 5,
    parameter int DWELL_W  = 8,
    localparam int GW = $clog2(N_GROUPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [15:0]        num_sweeps,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mask_we,
    input  logic [GW-1:0]      mask_addr,
    input  logic [N_PBITS-1:0] mask_data,
    output logic [0:N_PBITS-1] Pbit_EN,
    output logic [GW-1:0]      group_idx,
    output logic [15:0]        sweep_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StEn, StGuard} state_t;

    state_t             state;
    logic [N_PBITS-1:0] mask [N_GROUPS];
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_m1_l;
    logic [DWELL_W-1:0] dwell_m1;
    logic [15:0]        num_sweeps_l;
    logic [15:0]        sweep_inc;
    logic [GW-1:0]      first_grp;
    logic [GW-1:0]      next_grp;
    logic               has_first;
    logic               has_next;

    // Mask bit i drives Pbit_EN[i]; the output is declared ascending, so map bit by bit.
    function automatic logic [0:N_PBITS-1] to_en(input logic [N_PBITS-1:0] m);
        logic [0:N_PBITS-1] r;
        for (int i = 0; i < N_PBITS; i++) r[i] = m[i];
        return r;
    endfunction

    assign dwell_m1  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign sweep_inc = (sweep_cnt == 16'hFFFF) ? sweep_cnt : sweep_cnt + 16'd1;
    assign busy      = (state != StIdle);

    always_comb begin
        first_grp = '0;
        next_grp  = '0;
        has_first = 1'b0;
        has_next  = 1'b0;
`ifdef GROUP_SKIP_EMPTY_EN
        // Descending scan so the lowest qualifying group wins.
        for (int g = N_GROUPS - 1; g >= 0; g--) begin
            if (|mask[g]) begin
                first_grp = GW'(g);
                has_first = 1'b1;
                if (GW'(g) > group_idx) begin
                    next_grp = GW'(g);
                    has_next = 1'b1;
                end
            end
        end
`else
        has_first = 1'b1;
        has_next  = (group_idx != GW'(N_GROUPS - 1));
        next_grp  = group_idx + GW'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < N_GROUPS; g++) mask[g] <= '0;
        end else if (mask_we && !busy && (int'(mask_addr) < N_GROUPS)) begin
            mask[mask_addr] <= mask_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            Pbit_EN      <= '0;
            group_idx    <= '0;
            sweep_cnt    <= '0;
            done         <= 1'b0;
            dwell_cnt    <= '0;
            dwell_m1_l   <= '0;
            num_sweeps_l <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && !stop) begin
                        num_sweeps_l <= num_sweeps;
                        dwell_m1_l   <= dwell_m1;
                        sweep_cnt    <= '0;
                        if (has_first) begin
                            state     <= StEn;
                            group_idx <= first_grp;
                            Pbit_EN   <= to_en(mask[first_grp]);
                            dwell_cnt <= dwell_m1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                StEn: begin
                    if (stop) begin
                        state     <= StIdle;
                        Pbit_EN   <= '0;
                        group_idx <= '0;
                        done      <= 1'b1;
                    end else if (dwell_cnt == '0) begin
                        state   <= StGuard;
                        Pbit_EN <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                StGuard: begin
                    if (stop) begin
                        state     <= StIdle;
                        Pbit_EN   <= '0;
                        group_idx <= '0;
                        done      <= 1'b1;
                    end else if (has_next) begin
                        state     <= StEn;
                        group_idx <= next_grp;
                        Pbit_EN   <= to_en(mask[next_grp]);
                        dwell_cnt <= dwell_m1_l;
                    end else begin
                        sweep_cnt <= sweep_inc;
                        if ((num_sweeps_l != '0) && (sweep_inc == num_sweeps_l)) begin
                            state     <= StIdle;
                            group_idx <= '0;
                            done      <= 1'b1;
                        end else begin
                            state     <= StEn;
                            group_idx <= first_grp;
                            Pbit_EN   <= to_en(mask[first_grp]);
                            dwell_cnt <= dwell_m1_l;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_group_update_sequencer.sv
// Directed bench for group_update_sequencer (N_PBITS=8, N_GROUPS=3); honours GROUP_SKIP_EMPTY_EN.
module tb_group_update_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] num_sweeps;
    logic [7:0]  dwell;
    logic        mask_we;
    logic [1:0]  mask_addr;
    logic [7:0]  mask_data;
    logic [0:7]  Pbit_EN;
    logic [1:0]  group_idx;
    logic [15:0] sweep_cnt;
    logic        busy;
    logic        done;
    logic [7:0]  pen;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_basic [9] = '{8'h81, 8'h81, 8'h00, 8'h42, 8'h42, 8'h00, 8'h3C, 8'h3C, 8'h00};
    logic [7:0] exp_cont  [6] = '{8'h81, 8'h00, 8'h42, 8'h00, 8'h3C, 8'h00};
`ifdef GROUP_SKIP_EMPTY_EN
    localparam int NSKIP = 8;
    logic [7:0] exp_skip [NSKIP] = '{8'h81, 8'h00, 8'h3C, 8'h00, 8'h81, 8'h00, 8'h3C, 8'h00};
`else
    localparam int NSKIP = 12;
    logic [7:0] exp_skip [NSKIP] = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00,
                                     8'h81, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00};
`endif

    always #5 clk = ~clk;

    group_update_sequencer #(
        .N_PBITS (8),
        .N_GROUPS(3),
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .num_sweeps(num_sweeps),
        .dwell     (dwell),
        .mask_we   (mask_we),
        .mask_addr (mask_addr),
        .mask_data (mask_data),
        .Pbit_EN   (Pbit_EN),
        .group_idx (group_idx),
        .sweep_cnt (sweep_cnt),
        .busy      (busy),
        .done      (done)
    );

    // Pack so that pen[i] == Pbit_EN[i], matching mask bit numbering.
    always_comb begin
        pen = '0;
        for (int i = 0; i < 8; i++) pen[i] = Pbit_EN[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        mask_we   = 1'b1;
        mask_addr = a;
        mask_data = d;
        tick();
        mask_we   = 1'b0;
    endtask

    task automatic go(input logic [15:0] ns, input logic [7:0] dw);
        num_sweeps = ns;
        dwell      = dw;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; num_sweeps = '0; dwell = '0;
        mask_we = 1'b0; mask_addr = '0; mask_data = '0;
        tick();
        tick();
        chk("rst_pen", pen, 0);
        chk("rst_grp", group_idx, 0);
        chk("rst_sweep", sweep_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        wr(0, 8'h81); wr(1, 8'h42); wr(2, 8'h3C);

        // Basic single sweep, dwell 2
        go(1, 2);
        for (int i = 0; i < 9; i++) begin
            chk("basic_pen", pen, exp_basic[i]);
            chk("basic_grp", group_idx, i / 3);
            chk("basic_done", done, 0);
            tick();
        end
        chk("basic_end_done", done, 1);
        chk("basic_end_sweep", sweep_cnt, 1);
        chk("basic_end_busy", busy, 0);
        tick();
        chk("basic_done_once", done, 0);

        // Continuous run, dwell 0, stop after 20 cycles
        go(0, 0);
        for (int k = 0; k < 20; k++) begin
            chk("cont_pen", pen, exp_cont[k % 6]);
            chk("cont_sweep", sweep_cnt, k / 6);
            chk("cont_done", done, 0);
            if (k == 19) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        chk("stop_pen", pen, 0);
        chk("stop_done", done, 1);
        chk("stop_busy", busy, 0);
        chk("stop_sweep", sweep_cnt, 3);
        tick();
        chk("stop_done_once", done, 0);
        chk("stop_sweep_hold", sweep_cnt, 3);

        // Write while busy ignored; dwell/num_sweeps changes mid-run ignored
        go(1, 1);
        dwell = 8'd5; num_sweeps = 16'd9;
        wr(1, 8'hFF);
        tick();
        chk("busywr_g1", pen, 8'h42);
        tick(); tick();
        chk("latched_dwell_g2", pen, 8'h3C);
        tick();
        chk("latched_dwell_guard", pen, 0);
        tick();
        chk("latched_ns_done", done, 1);
        wait_idle("busywr_idle");
        go(1, 1);
        tick(); tick();
        chk("busywr_next_run", pen, 8'h42);
        wait_idle("busywr_idle2");
        wr(1, 8'hFF);
        wr(3, 8'hAA);
        go(1, 1);
        chk("idlewr_g0", pen, 8'h81);
        tick(); tick();
        chk("idlewr_g1", pen, 8'hFF);
        tick(); tick();
        chk("idlewr_g2", pen, 8'h3C);
        wait_idle("idlewr_idle");

        // Reset during EN of group 2
        go(1, 1);
        tick(); tick(); tick(); tick();
        chk("prerst_pen", pen, 8'h3C);
        chk("prerst_grp", group_idx, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("asyncrst_pen", pen, 0);
        chk("asyncrst_busy", busy, 0);
        chk("asyncrst_grp", group_idx, 0);
        chk("asyncrst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_done", done, 0);
        go(1, 1);
`ifdef GROUP_SKIP_EMPTY_EN
        chk("allzero_done", done, 1);
        chk("allzero_busy", busy, 0);
        chk("allzero_sweep", sweep_cnt, 0);
        tick();
        chk("allzero_done_once", done, 0);
`else
        chk("zeromask_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            chk("zeromask_pen", pen, 0);
            tick();
        end
        chk("zeromask_done", done, 1);
        wait_idle("zeromask_idle");
`endif

        // Start/stop collision, then start during a run
        wr(0, 8'h81); wr(1, 8'h42); wr(2, 8'h3C);
        num_sweeps = 16'd1; dwell = 8'd1;
        start = 1'b1; stop = 1'b1;
        tick();
        chk("collide_busy", busy, 0);
        chk("collide_done", done, 0);
        start = 1'b0; stop = 1'b0;
        tick();
        chk("collide_done2", done, 0);
        go(1, 1);
        start = 1'b1;
        tick(); tick();
        chk("restart_grp1", group_idx, 1);
        chk("restart_pen", pen, 8'h42);
        start = 1'b0;
        tick(); tick();
        chk("restart_grp2", group_idx, 2);
        wait_idle("restart_idle");

        // Empty middle group, two sweeps
        wr(1, 8'h00);
        go(2, 1);
        for (int i = 0; i < NSKIP; i++) begin
            chk("skip_pen", pen, exp_skip[i]);
            chk("skip_done", done, 0);
            tick();
        end
        chk("skip_end_done", done, 1);
        chk("skip_end_sweep", sweep_cnt, 2);
        chk("skip_end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
